// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage controller. Each cycle it chooses the next PC (sequential,
// branch, jump, exception vector or hold) against an instruction memory with
// variable latency. Redirects that arrive while a fetch is still outstanding
// are parked in a one-entry pending buffer. The buffered redirect is applied
// when that fetch completes.
//
// Parameters
//   RESET_VECTOR     PC value presented while the block is in reset
//   EXC_VECTOR       exception handler address
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   pc               current PC from the PC register
//   stall_d          decode-stage stall from the hazard unit
//   exc              exception request
//   jump             jump resolved in decode
//   jump_target      jump destination
//   branch_taken     taken branch resolved in decode
//   branch_target    branch destination
//   imem_ready       instruction memory returns data this cycle
//   imem_req         fetch request valid
//   imem_addr        word-aligned fetch address
//   pc_next          next-PC value to the PC register (combinational)
//   stall_f          hold the PC register (combinational)
//   flush_d          discard the instruction entering decode (combinational)
//   redirect_pending a buffered redirect is valid (registered)
//   stall_cnt        saturating count of fetch stall cycles (registered)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stall_d,
  input  logic        exc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_next,
  output logic        stall_f,
  output logic        flush_d,
  output logic        redirect_pending,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    RST_S = 1'b0,
    FETCH = 1'b1
  } state_e;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // The PC register is held whenever a fetch is outstanding. This keeps the
  // address stable for the memory without a separate address register.
  assign imem_addr        = {pc[31:2], 2'b00};
  assign redirect_pending = pend_valid_q;
  assign stall_cnt        = stall_cnt_q;

  // ---------------------------------------------------------------------------
  // Next-state, pending buffer and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that leaves
    // one unassigned would otherwise infer a latch.
    state_d       = FETCH;          // RST_S always leaves on the first edge
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    stall_cnt_d   = stall_cnt_q;
    imem_req      = 1'b0;
    stall_f       = 1'b1;
    flush_d       = 1'b0;
    pc_next       = RESET_VECTOR;

    if (state_q == FETCH) begin
      imem_req = 1'b1;

      if (imem_ready) begin
        // Fetch completes. A buffered redirect is applied here even when
        // decode is stalled, because the stalled instruction is being flushed.
        if (exc) begin
          pc_next      = EXC_VECTOR;
          stall_f      = 1'b0;
          flush_d      = 1'b1;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          pc_next      = pend_target_q;
          stall_f      = 1'b0;
          flush_d      = 1'b1;
          pend_valid_d = 1'b0;
        end else if (stall_d) begin
          // Decode-stage redirects are ignored while decode is stalled.
          // The hazard unit presents them again once the stall clears.
          pc_next = pc;
          stall_f = 1'b1;
        end else if (jump) begin
          pc_next = jump_target;
          stall_f = 1'b0;
          flush_d = 1'b1;
        end else if (branch_taken) begin
          pc_next = branch_target;
          stall_f = 1'b0;
          flush_d = 1'b1;
        end else begin
          pc_next = pc + 32'd4;     // wraps modulo 2^32
          stall_f = 1'b0;
        end
      end else begin
        // Fetch outstanding: hold the PC and remember any redirect.
        pc_next = pc;
        stall_f = 1'b1;
        if (exc) begin
          // An exception replaces whatever was buffered.
          pend_valid_d  = 1'b1;
          pend_target_d = EXC_VECTOR;
        end else if (!stall_d && !pend_valid_q && (jump || branch_taken)) begin
          pend_valid_d  = 1'b1;
          pend_target_d = jump ? jump_target : branch_target;
        end
      end

      if (stall_f && (stall_cnt_q != STALL_CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the values from before the edge, whatever the evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_S;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      stall_cnt_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam logic [31:0] EXC_V = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        stall_d = 1'b0, exc = 1'b0, jump = 1'b0, branch_taken = 1'b0;
  logic [31:0] jump_target = '0, branch_target = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req, stall_f, flush_d, redirect_pending;
  logic [31:0] imem_addr, pc_next;
  logic [15:0] stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .stall_d          (stall_d),
    .exc              (exc),
    .jump             (jump),
    .jump_target      (jump_target),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_ready       (imem_ready),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .pc_next          (pc_next),
    .stall_f          (stall_f),
    .flush_d          (flush_d),
    .redirect_pending (redirect_pending),
    .stall_cnt        (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: "has a fetch cycle begun since reset", a queue holding at
  // most one parked redirect, and an integer stall count.
  // ---------------------------------------------------------------------------
  bit          m_fetching = 1'b0;
  logic [31:0] m_pend[$];
  int          m_cnt = 0;

  typedef struct packed {
    logic        req;
    logic        sf;
    logic        fl;
    logic [31:0] nx;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    e = '{req: 1'b0, sf: 1'b1, fl: 1'b0, nx: 32'h0};
    if (rst || !m_fetching) return e;
    e.req = 1'b1;
    e.nx  = pc;
    if (!imem_ready) return e;
    // Completion: pick the redirect target in priority order, or move on.
    if (exc)                        begin e.nx = EXC_V;          e.fl = 1'b1; e.sf = 1'b0; end
    else if (m_pend.size() != 0)    begin e.nx = m_pend[0];      e.fl = 1'b1; e.sf = 1'b0; end
    else if (stall_d)               begin e.nx = pc;                                     end
    else if (jump)                  begin e.nx = jump_target;    e.fl = 1'b1; e.sf = 1'b0; end
    else if (branch_taken)          begin e.nx = branch_target;  e.fl = 1'b1; e.sf = 1'b0; end
    else                            begin e.nx = pc + 32'd4;                  e.sf = 1'b0; end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      m_fetching = 1'b0;
      m_pend.delete();
      m_cnt = 0;
    end else begin
      e = model_out();
      if (m_fetching) begin
        if (e.sf && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (imem_ready) begin
          if (exc || m_pend.size() != 0) m_pend.delete();
        end else if (exc) begin
          m_pend.delete();
          m_pend.push_back(EXC_V);
        end else if (!stall_d && m_pend.size() == 0 && (jump || branch_taken)) begin
          m_pend.push_back(jump ? jump_target : branch_target);
        end
      end
      m_fetching = 1'b1;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    check("cmp imem_req", {31'b0, imem_req}, {31'b0, e.req});
    check("cmp stall_f",  {31'b0, stall_f},  {31'b0, e.sf});
    check("cmp flush_d",  {31'b0, flush_d},  {31'b0, e.fl});
    check("cmp pc_next",  pc_next, e.nx);
    check("cmp imem_addr", imem_addr, {pc[31:2], 2'b00});
    check("cmp redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend.size() != 0});
    check("cmp stall_cnt", {16'b0, stall_cnt}, m_cnt[31:0]);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ---------------------------------------------------------------------------
  initial begin
    repeat (2) next_cycle();
    #1;
    check("reset imem_req", {31'b0, imem_req}, 32'd0);
    check("reset stall_f", {31'b0, stall_f}, 32'd1);
    check("reset pc_next", pc_next, 32'h0);
    check("reset redirect_pending", {31'b0, redirect_pending}, 32'd0);
    check("reset stall_cnt", {16'b0, stall_cnt}, 32'd0);
    rst = 1'b0;
    #1 check("rst_s after release imem_req", {31'b0, imem_req}, 32'd0);

    // Sequential fetch
    next_cycle(); pc = 32'h100; imem_ready = 1'b1;
    #1 check("seq imem_req", {31'b0, imem_req}, 32'd1);
    check("seq pc_next 0x100", pc_next, 32'h104);
    check("seq stall_f", {31'b0, stall_f}, 32'd0);
    next_cycle(); pc = 32'h104;
    #1 check("seq pc_next 0x104", pc_next, 32'h108);
    next_cycle(); pc = 32'hFFFF_FFFC;
    #1 check("seq wrap", pc_next, 32'h0);

    // Slow memory: three wait cycles, unaligned PC low bits masked
    next_cycle(); pc = 32'h302; imem_ready = 1'b0;
    #1 check("slow addr 1", imem_addr, 32'h300);
    check("slow hold", pc_next, 32'h302);
    check("slow stall_f", {31'b0, stall_f}, 32'd1);
    next_cycle(); #1 check("slow addr 2", imem_addr, 32'h300);
    next_cycle(); #1 check("slow addr 3", imem_addr, 32'h300);
    next_cycle(); imem_ready = 1'b1;
    #1 check("slow stall_cnt", {16'b0, stall_cnt}, 32'd3);
    check("slow complete", pc_next, 32'h306);

    // Buffered branch
    next_cycle(); pc = 32'h308; imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    #1 check("bbr not yet pending", {31'b0, redirect_pending}, 32'd0);
    next_cycle(); branch_taken = 1'b0;
    #1 check("bbr pending", {31'b0, redirect_pending}, 32'd1);
    check("bbr hold", pc_next, 32'h308);
    next_cycle(); imem_ready = 1'b1;
    #1 check("bbr target", pc_next, 32'h200);
    check("bbr flush", {31'b0, flush_d}, 32'd1);
    next_cycle(); pc = 32'h200;
    #1 check("bbr cleared", {31'b0, redirect_pending}, 32'd0);
    check("bbr flush one cycle", {31'b0, flush_d}, 32'd0);
    check("bbr stall_cnt", {16'b0, stall_cnt}, 32'd5);

    // A branch never overwrites a buffered jump
    next_cycle(); imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h400;
    next_cycle(); jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h500;
    next_cycle(); branch_taken = 1'b0; imem_ready = 1'b1;
    #1 check("keep first pending", pc_next, 32'h400);

    // An exception overwrites a buffered jump
    next_cycle(); pc = 32'h400; imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h440;
    next_cycle(); jump = 1'b0; exc = 1'b1;
    next_cycle(); exc = 1'b0; imem_ready = 1'b1;
    #1 check("exc overwrites pending", pc_next, EXC_V);

    // Pending applied even with stall_d on the completing cycle
    next_cycle(); pc = 32'h180; imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h600;
    next_cycle(); branch_taken = 1'b0; imem_ready = 1'b1; stall_d = 1'b1;
    #1 check("pending under stall_d", pc_next, 32'h600);
    check("pending under stall_d flush", {31'b0, flush_d}, 32'd1);
    next_cycle(); stall_d = 1'b0; pc = 32'h600;

    // Priority on completion
    exc = 1'b1; jump = 1'b1; branch_taken = 1'b1; jump_target = 32'h800; branch_target = 32'h900;
    #1 check("prio exc", pc_next, EXC_V);
    check("prio exc flush", {31'b0, flush_d}, 32'd1);
    next_cycle(); exc = 1'b0;
    #1 check("prio jump", pc_next, 32'h800);
    next_cycle(); jump = 1'b0;
    #1 check("prio branch", pc_next, 32'h900);

    // Exception on completion drops a buffered entry
    next_cycle(); branch_taken = 1'b0; imem_ready = 1'b0; jump = 1'b1; jump_target = 32'hA00;
    next_cycle(); jump = 1'b0; imem_ready = 1'b1; exc = 1'b1;
    #1 check("exc beats pending", pc_next, EXC_V);
    next_cycle(); exc = 1'b0;
    #1 check("exc dropped pending", {31'b0, redirect_pending}, 32'd0);

    // Stall interaction
    pc = 32'h900; stall_d = 1'b1; jump = 1'b1; jump_target = 32'hA00;
    #1 check("stall_d stall_f", {31'b0, stall_f}, 32'd1);
    check("stall_d pc_next", pc_next, 32'h900);
    check("stall_d flush", {31'b0, flush_d}, 32'd0);
    next_cycle(); imem_ready = 1'b0;
    #1 check("stall_d no capture 1", {31'b0, redirect_pending}, 32'd0);
    next_cycle();
    #1 check("stall_d no capture 2", {31'b0, redirect_pending}, 32'd0);
    stall_d = 1'b0; jump = 1'b0;

    // Reset mid-fetch with a pending entry
    next_cycle(); jump = 1'b1; jump_target = 32'hB00;
    next_cycle(); jump = 1'b0;
    #1 check("pre-reset pending", {31'b0, redirect_pending}, 32'd1);
    rst = 1'b1;
    #1 check("async rst imem_req", {31'b0, imem_req}, 32'd0);
    check("async rst stall_f", {31'b0, stall_f}, 32'd1);
    check("async rst pc_next", pc_next, 32'h0);
    check("async rst pending", {31'b0, redirect_pending}, 32'd0);
    check("async rst flush", {31'b0, flush_d}, 32'd0);
    next_cycle(); rst = 1'b0;
    #1 check("post-rst rst_s", {31'b0, imem_req}, 32'd0);
    next_cycle();
    #1 check("post-rst fetch", {31'b0, imem_req}, 32'd1);
    check("post-rst stall_cnt", {16'b0, stall_cnt}, 32'd0);

    repeat (3) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller that sequences the program counter register against a variable-latency instruction memory. Each cycle it selects the next PC: sequential, branch, jump, exception vector, or hold. It drives the PC register's next-value and stall inputs, issues instruction-memory requests and flushes the decode stage on redirects. Redirects that arrive while a fetch is outstanding are buffered until that fetch completes.

## Interface

- `RESET_VECTOR`, 32'h0000_0000: PC value presented while in reset state.
- `EXC_VECTOR`, 32'h0000_0180: exception handler address.

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `pc`, in, 32: current PC from the PC register.
- `stall_d`, in, 1: decode-stage stall from the hazard unit.
- `exc`, in, 1: exception request.
- `jump`, in, 1: jump resolved in decode.
- `jump_target`, in, 32: jump destination.
- `branch_taken`, in, 1: taken branch resolved in decode.
- `branch_target`, in, 32: branch destination.
- `imem_ready`, in, 1: instruction memory returns data this cycle.
- `imem_req`, out, 1: fetch request valid.
- `imem_addr`, out, 32: fetch address, `{pc[31:2],2'b00}`.
- `pc_next`, out, 32: next-PC value to the PC register.
- `stall_f`, out, 1: hold the PC register.
- `flush_d`, out, 1: discard the instruction entering decode.
- `redirect_pending`, out, 1: a buffered redirect is valid.
- `stall_cnt`, out, 16: saturating count of fetch stall cycles.

## Operation

- **States:** `RST_S` and `FETCH`.
  - `rst` forces `RST_S`.
  - The first clock edge after `rst` falls moves to `FETCH`, unconditionally.
  - The block stays in `FETCH` until the next reset.
- **In `RST_S`:**
  - `imem_req`=0, `stall_f`=1, `flush_d`=0, `pc_next`=`RESET_VECTOR`.
- **In `FETCH`:** `imem_req`=1. The following rules are evaluated in order.
- **When `imem_ready`=1 (fetch completes):**
  1. `exc`=1: `pc_next`=`EXC_VECTOR`, `stall_f`=0, `flush_d`=1. The pending buffer is cleared.
  2. pending valid: `pc_next`=pending target, `stall_f`=0, `flush_d`=1. The pending buffer is cleared.
  3. `stall_d`=1: `stall_f`=1, `pc_next`=`pc`, `flush_d`=0.
  4. `jump`=1: `pc_next`=`jump_target`, `stall_f`=0, `flush_d`=1.
  5. `branch_taken`=1: `pc_next`=`branch_target`, `stall_f`=0, `flush_d`=1.
  6. otherwise: `pc_next`=`pc`+4 (modulo 2^32, wraps), `stall_f`=0, `flush_d`=0.
- **When `imem_ready`=0 (fetch outstanding):**
  - `stall_f`=1, `pc_next`=`pc`, `flush_d`=0.
  - `exc`=1: load pending with `EXC_VECTOR`. This overwrites any existing pending entry.
  - else if `stall_d`=0, no pending entry, and `jump` or `branch_taken` is set: load pending with that target. Jump wins if both are set.
  - A jump or branch never overwrites a valid pending entry.
- **Redirects while `stall_d`=1:**
  - `jump` and `branch_taken` are ignored; the hazard unit re-presents them.
  - `exc` is always honored.
- **`stall_cnt`:**
  - Increments on every `FETCH` cycle in which `stall_f`=1.
  - Saturates at 16'hFFFF.
  - Cleared only by `rst`.

## Timing

- **Reset values:**
  - state `RST_S`, pending valid 0, pending target 0, `stall_cnt` 0.
  - Outputs: `imem_req` 0, `stall_f` 1, `flush_d` 0, `redirect_pending` 0, `pc_next` `RESET_VECTOR`.
- **Combinational outputs:** `pc_next`, `stall_f`, `flush_d` and `imem_req` are combinational from state, pending and inputs. Zero-cycle latency to the PC register.
- **Registered outputs:** the pending buffer and `stall_cnt` update on the rising edge. `redirect_pending` is high from the cycle after capture until the cycle after consumption.
- **Pending consumption:** a pending redirect is applied on the first `imem_ready`=1 cycle, even if that cycle also has `stall_d`=1.
- **Exception vs pending on completion:** when `exc` and a completing fetch coincide with a pending entry, `EXC_VECTOR` is used and the pending entry is dropped.
- **Reset during an outstanding fetch:**
  - The pending entry is discarded and `imem_req` drops immediately (asynchronous).
  - No flush is issued.
- **Memory side:** `imem_addr` is held stable while `imem_req`=1 and `imem_ready`=0.

## Test plan

- **Reset:** assert `rst` mid-fetch with pending valid. Expect `imem_req`=0, `stall_f`=1, `pc_next`=0, `redirect_pending`=0 immediately. The cycle after `rst` falls, `imem_req`=1.
- **Sequential fetch:** `pc`=0x100, `imem_ready`=1 constantly. Expect `pc_next`=0x104 and `stall_f`=0 each cycle. Then `pc`=0xFFFF_FFFC gives `pc_next`=0x0000_0000.
- **Slow memory:** `imem_ready` low for 3 cycles. Expect `stall_f`=1 and `pc_next`=`pc` for 3 cycles, `imem_addr` stable, and `stall_cnt` incremented by 3.
- **Buffered branch:** `branch_taken`=1 with `branch_target`=0x200 while `imem_ready`=0.
  - Next cycle `redirect_pending`=1.
  - When ready arrives: `pc_next`=0x200, `flush_d`=1 for one cycle, pending cleared.
- **Priority:** `exc`, `jump` and `branch_taken` all high with `imem_ready`=1. Expect `pc_next`=0x180 and `flush_d`=1. Repeat with `exc`=0: expect `jump_target`.
- **Stall interaction:** `stall_d`=1 with `jump`=1 and `imem_ready`=1. Expect `stall_f`=1, `pc_next`=`pc`, `flush_d`=0, and no pending capture.
